// File: rtl/nn_pkg.sv
// Shared constants, sequencer state encoding and the Q8.8 saturation helper
// for the layer-2 neuron datapath.
package nn_pkg;

  localparam int N_IN  = 56;
  localparam int N_OUT = 10;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_DONE,
    S_ERR
  } seq_state_e;

  // Clamp an already-shifted accumulator value into signed 16-bit Q8.8.
  function automatic logic [DW-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (longint'(v) > 32767)  return 16'h7FFF;
    if (longint'(v) < -32768) return 16'h8000;
    return v[DW-1:0];
  endfunction

endpackage

// File: rtl/q88_mac.sv
// Signed Q8.8 multiply-accumulate with clear; exposes the saturated result of
// the accumulator including the product being added this cycle.
module q88_mac #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] sat_next_o
);
  import nn_pkg::*;

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_q, acc_d, shifted;

  assign prod    = $signed(a_i) * $signed(b_i);
  assign acc_d   = en_i ? acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod} : acc_q;
  // Arithmetic shift floors toward -inf before clamping.
  assign shifted = acc_d >>> FRAC;
  assign sat_next_o = sat16(shifted);

  always_ff @(posedge clk) begin
    if (rst || clr_i) acc_q <= '0;
    else              acc_q <= acc_d;
  end

endmodule

// File: rtl/l2_neuron_sequencer.sv
// Walks the layer-1 activations through the fetch port, accumulates
// activation*weight per layer-2 neuron and emits one saturated result each.
module l2_neuron_sequencer #(
  parameter int N_IN  = 56,
  parameter int N_OUT = 10,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40,
  parameter int TMO   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          l1_fetch,
  output logic [5:0]    l1_no,
  input  logic          l1_fetched,
  input  logic [DW-1:0] l1_value,
  output logic [9:0]    w_addr,
  input  logic [DW-1:0] w_data,
  output logic          out_valid,
  output logic [3:0]    out_idx,
  output logic [DW-1:0] out_data
);
  import nn_pkg::*;

  localparam int TW = $clog2(TMO + 1);

  seq_state_e    state_q;
  logic [5:0]    idx_q;
  logic [3:0]    neu_q;
  logic [TW-1:0] tmo_q;
  logic          busy_q, done_q, err_q, fetch_q, valid_q;
  logic [5:0]    l1_no_q;
  logic [9:0]    w_addr_q;
  logic [3:0]    out_idx_q;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] mac_sat;
  logic          mac_en, mac_clr;

  function automatic logic [9:0] waddr(input logic [3:0] n, input logic [5:0] i);
    return 10'(int'(n) * N_IN) + 10'(i);
  endfunction

  assign mac_en  = (state_q == S_WAIT) && l1_fetched;
  assign mac_clr = (state_q == S_OUT) || (state_q == S_ERR);

  q88_mac #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (mac_clr),
    .en_i       (mac_en),
    .a_i        (l1_value),
    .b_i        (w_data),
    .sat_next_o (mac_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      neu_q      <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fetch_q    <= 1'b0;
      valid_q    <= 1'b0;
      l1_no_q    <= '0;
      w_addr_q   <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      fetch_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q  <= S_FETCH;
          busy_q   <= 1'b1;
          err_q    <= 1'b0;
          fetch_q  <= 1'b1;
          idx_q    <= '0;
          neu_q    <= '0;
          l1_no_q  <= '0;
          w_addr_q <= '0;
        end
        S_FETCH: begin
          state_q <= S_WAIT;
          tmo_q   <= '0;
        end
        S_WAIT: if (l1_fetched) begin
          tmo_q <= '0;
          if (idx_q == 6'(N_IN - 1)) begin
            // Result includes the product being accumulated on this edge.
            state_q    <= S_OUT;
            valid_q    <= 1'b1;
            out_idx_q  <= neu_q;
            out_data_q <= mac_sat;
          end else begin
            state_q  <= S_FETCH;
            idx_q    <= idx_q + 6'd1;
            fetch_q  <= 1'b1;
            l1_no_q  <= idx_q + 6'd1;
            w_addr_q <= waddr(neu_q, idx_q + 6'd1);
          end
        end else if (tmo_q == TW'(TMO - 1)) begin
          state_q <= S_ERR;
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
        S_OUT: begin
          idx_q <= '0;
          if (neu_q == 4'(N_OUT - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            neu_q   <= '0;
          end else begin
            state_q  <= S_FETCH;
            neu_q    <= neu_q + 4'd1;
            fetch_q  <= 1'b1;
            l1_no_q  <= '0;
            w_addr_q <= waddr(neu_q + 4'd1, 6'd0);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_ERR: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
          neu_q   <= '0;
          tmo_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign l1_fetch  = fetch_q;
  assign l1_no     = l1_no_q;
  assign w_addr    = w_addr_q;
  assign out_valid = valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_l2_neuron_sequencer.sv
// Bench: registered fetch responder and weight ROM, dot-product reference
// model, directed and random runs including timeout and mid-run reset.
module tb_l2_neuron_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err, l1_fetch, out_valid;
  logic [5:0]  l1_no;
  logic        l1_fetched;
  logic [15:0] l1_value, w_data, out_data;
  logic [9:0]  w_addr;
  logic [3:0]  out_idx;

  always #5 clk = ~clk;

  l2_neuron_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .l1_fetch   (l1_fetch),
    .l1_no      (l1_no),
    .l1_fetched (l1_fetched),
    .l1_value   (l1_value),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_data   (out_data)
  );

  logic signed [15:0] act  [56];
  logic signed [15:0] wrom [1024];
  bit withhold = 1'b0;

  // One-cycle registered responder and ROM; withholds neuron 3 input 10 on request.
  always @(posedge clk) begin
    if (rst) l1_fetched <= 1'b0;
    else     l1_fetched <= l1_fetch && !(withhold && w_addr == 10'd178);
    l1_value <= (l1_no < 6'd56) ? act[l1_no] : 16'h0000;
    w_data   <= wrom[w_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int n);
    longint s = 0;
    for (int i = 0; i < 56; i++) s += longint'(act[i]) * longint'(wrom[n*56 + i]);
    s = s >>> 8;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  logic [3:0]  q_idx [$];
  logic [15:0] q_dat [$];
  int busy_cnt, first_busy, first_valid, last_valid, done_at, done_cnt, err_at;

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_err"},       err,       0);
    chk({tag, "_fetch"},     l1_fetch,  0);
    chk({tag, "_valid"},     out_valid, 0);
    chk({tag, "_l1_no"},     l1_no,     0);
    chk({tag, "_w_addr"},    w_addr,    0);
    chk({tag, "_out_idx"},   out_idx,   0);
    chk({tag, "_out_data"},  out_data,  0);
  endtask

  // start sampled at rel 0; a stray start is pulsed at rel 300.
  task automatic run(input string tag, input int rst_at);
    bit ended = 1'b0;
    q_idx.delete(); q_dat.delete();
    busy_cnt = 0; first_busy = -1; first_valid = -1; last_valid = -1;
    done_at = -1; done_cnt = 0; err_at = -1;
    @(negedge clk); start = 1'b1;
    for (int rel = 1; rel <= 3000 && !ended; rel++) begin
      @(negedge clk);
      if (rel == 1 || rel == 301) start = 1'b0;
      if (rel == 300) start = 1'b1;
      if (busy) begin busy_cnt++; if (first_busy < 0) first_busy = rel; end
      if (out_valid) begin
        q_idx.push_back(out_idx); q_dat.push_back(out_data);
        if (first_valid < 0) first_valid = rel;
        last_valid = rel;
      end
      if (done) begin done_cnt++; done_at = rel; ended = 1'b1; end
      if (err && err_at < 0) begin err_at = rel; ended = 1'b1; end
      if (rst_at > 0 && rel == rst_at) rst = 1'b1;
      if (rst_at > 0 && rel == rst_at + 1) begin
        chk_reset({tag, "_rst"}); rst = 1'b0; ended = 1'b1;
      end
    end
    chk({tag, "_ended"}, ended, 1);
  endtask

  task automatic check_outs(input string tag, input int nexp);
    chk({tag, "_count"}, q_dat.size(), nexp);
    for (int k = 0; k < nexp && k < q_dat.size(); k++) begin
      chk($sformatf("%s_idx%0d", tag, k),  q_idx[k], k);
      chk($sformatf("%s_data%0d", tag, k), q_dat[k], model(k));
    end
  endtask

  initial begin
    for (int i = 0; i < 56; i++) act[i] = 16'h0000;
    for (int i = 0; i < 1024; i++) wrom[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // All ones: 56 * 1.0 = 56.0 -> 0x3800, plus full timing profile.
    for (int i = 0; i < 56; i++) act[i] = 16'h0100;
    for (int i = 0; i < 560; i++) wrom[i] = 16'h0100;
    run("ones", 0);
    check_outs("ones", 10);
    if (q_dat.size() > 0) chk("ones_const", q_dat[0], 16'h3800);
    chk("first_busy", first_busy, 1);
    chk("busy_cycles", busy_cnt, 1131);
    chk("first_valid", first_valid, 113);
    chk("last_valid", last_valid, 1130);
    chk("done_at", done_at, 1131);
    chk("done_cnt", done_cnt, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);

    // Positive and negative saturation.
    for (int i = 0; i < 56; i++) act[i] = 16'h7FFF;
    for (int i = 0; i < 560; i++) wrom[i] = 16'h7FFF;
    run("satpos", 0);
    check_outs("satpos", 10);
    for (int i = 0; i < 560; i++) wrom[i] = 16'h8000;
    run("satneg", 0);
    check_outs("satneg", 10);

    // Half +1.0, half -1.0 cancels to zero.
    for (int i = 0; i < 56; i++) act[i] = (i < 28) ? 16'h0100 : 16'hFF00;
    for (int i = 0; i < 560; i++) wrom[i] = 16'h0100;
    run("cancel", 0);
    check_outs("cancel", 10);

    // Random full-range and small-range operands.
    for (int i = 0; i < 56; i++) act[i] = 16'($urandom);
    for (int i = 0; i < 560; i++) wrom[i] = 16'($urandom);
    run("rnd_full", 0);
    check_outs("rnd_full", 10);
    for (int i = 0; i < 56; i++) act[i] = 16'(int'($urandom_range(0, 1023)) - 512);
    for (int i = 0; i < 560; i++) wrom[i] = 16'(int'($urandom_range(0, 255)) - 128);
    run("rnd_small", 0);
    check_outs("rnd_small", 10);

    // Fetch timeout at neuron 3, input 10: FETCH at 360, WAIT 361..368.
    withhold = 1'b1;
    run("tmo", 0);
    chk("tmo_err_at", err_at, 1 + 113*3 + 2*10 + 9);
    chk("tmo_done_cnt", done_cnt, 0);
    check_outs("tmo", 3);
    repeat (3) @(negedge clk);
    chk("tmo_busy_idle", busy, 0);
    chk("tmo_err_sticky", err, 1);
    chk("tmo_no_done", done, 0);
    withhold = 1'b0;
    run("after_err", 0);
    chk("after_err_cleared", err_at, -1);
    check_outs("after_err", 10);

    // Mid-run reset then a clean run.
    run("midrst", 500);
    run("post_rst", 0);
    check_outs("post_rst", 10);
    chk("post_rst_done_at", done_at, 1131);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
